sram_controller: RTL and testbench
==================================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 Parameter: WAIT_CYCLES, 5, number of cycles SRAM_ADDR/SRAM_WE_N are held per SRAM access (legal range 2..15).
REQ-002 Parameter: BASE_ADDR, 1024, byte address of data memory word 0.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 wr_en  input  1  MEM-stage store request.
REQ-006 rd_en  input  1  MEM-stage load request.
REQ-007 address  input  32  byte address from ALU; word aligned.
REQ-008 write_data  input  32  store data.
REQ-009 read_data  output  32  load result.
REQ-010 ready  output  1  access complete; pipeline freeze = ~ready.
REQ-011 SRAM_WE_N  output  1  SRAM write enable, active-low.
REQ-012 SRAM_ADDR  output  17  SRAM word address.
REQ-013 SRAM_DQ  inout  64  SRAM data bus; SRAM returns {word[addr|1], word[addr&~1]}.

Function
REQ-014 States IDLE, ACCESS, DONE.
REQ-015 IDLE: if wr_en or rd_en, latch address, write_data and op (write when wr_en, regardless of rd_en) -> ACCESS, counter=0; else stay IDLE.
REQ-016 ACCESS: counter increments each cycle; at counter==WAIT_CYCLES-1 -> DONE; ACCESS lasts exactly WAIT_CYCLES cycles.
REQ-017 DONE: one cycle, then IDLE unconditionally; a request still asserted is sampled again only in IDLE.
REQ-018 ready = ~(wr_en|rd_en) in IDLE, 0 in ACCESS, 1 in DONE; request in cycle N gives ready=1 in cycle N+WAIT_CYCLES+1.
REQ-019 SRAM_ADDR = latched (address-BASE_ADDR)[18:2], held stable through ACCESS.
REQ-020 SRAM_WE_N = 0 only during ACCESS of a write; 1 in all other states.
REQ-021 SRAM_DQ driven with {32'b0, latched write_data} when SRAM_WE_N=0, else high-Z.
REQ-022 Read: on the ACCESS->DONE edge read_data <= SRAM_ADDR[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0].
REQ-023 read_data holds its value until the next read completes; writes never change it.
REQ-024 Input changes during ACCESS/DONE are ignored; only latched values drive SRAM.

Reset
REQ-025 rst=1 at posedge: state=IDLE, counter=0, read_data=0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ high-Z, line buffer invalid.
REQ-026 rst mid-ACCESS aborts the access; SRAM_WE_N=1 from that edge; no DONE cycle produced.
REQ-027 rst dominates any simultaneous request.

Configuration
REQ-028 Macro SRAM_LINE_BUF_EN compiles in a one-entry 64-bit line buffer (valid bit, tag = SRAM_ADDR[16:1]).
REQ-029 With macro: read in IDLE hitting a valid tag -> DONE next cycle (ready in cycle N+1), read_data from buffer half selected by SRAM_ADDR[0], no SRAM access.
REQ-030 With macro: read miss -> normal access; at ACCESS->DONE the full 64-bit SRAM_DQ and tag are loaded, valid=1.
REQ-031 With macro: write always performs a full access; if tag hits, the matching 32-bit half is updated with write_data at ACCESS->DONE.
REQ-032 Without macro: no buffer logic; every read takes full latency (REQ-018).

Verification
REQ-033 Reset, write 0xDEADBEEF @1024 -> SRAM_ADDR=0, SRAM_WE_N=0 for 5 cycles, SRAM_DQ[31:0]=0xDEADBEEF, ready=1 at cycle 6.
REQ-034 Then read @1024 -> ready=1 at cycle 6, read_data=0xDEADBEEF, SRAM_WE_N stays 1.
REQ-035 Write 0x11111111 @1028, 0x22222222 @1024, read @1028 -> read_data=0x11111111; read @1024 -> 0x22222222.
REQ-036 wr_en=rd_en=1 @1032 data 0x5A5A5A5A -> write performed (SRAM_WE_N=0), read_data unchanged.
REQ-037 rst asserted in 3rd ACCESS cycle of a write -> next cycle IDLE, SRAM_WE_N=1, ready=~request.
REQ-038 SRAM_LINE_BUF_EN: read @1024 twice, then @1028 -> 2nd and 3rd ready at N+1; write 0x33333333 @1028 then read @1028 -> hit returns 0x33333333; without macro all reads take 6 cycles.

Source files
------------

// File: rtl/sram_controller.sv
// ============================================================================
// Module   : sram_controller
// Purpose  : MEM-stage bridge to a 64-bit SRAM with fixed-latency accesses.
// Options  : SRAM_LINE_BUF_EN adds a one-entry 64-bit read line buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_controller #(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        SRAM_WE_N,
  output logic [16:0] SRAM_ADDR,
  inout  wire  [63:0] SRAM_DQ
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] c_last_cnt = 4'(WAIT_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        op_wr_q;
  logic        we_n_q;
  logic [16:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] read_data_q;
  logic [16:0] w_req_word;
  logic        w_req;

  assign w_req      = wr_en | rd_en;
  assign w_req_word = 17'((address - BASE_ADDR) >> 2);

`ifdef SRAM_LINE_BUF_EN
  logic        lb_valid_q;
  logic [15:0] lb_tag_q;
  logic [63:0] lb_data_q;
  logic        w_lb_hit;

  assign w_lb_hit = lb_valid_q && (lb_tag_q == w_req_word[16:1]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_wr_q     <= 1'b0;
      we_n_q      <= 1'b1;
      addr_q      <= 17'd0;
      wdata_q     <= 32'd0;
      read_data_q <= 32'd0;
`ifdef SRAM_LINE_BUF_EN
      lb_valid_q  <= 1'b0;
      lb_tag_q    <= 16'd0;
      lb_data_q   <= 64'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (w_req) begin
            addr_q  <= w_req_word;
            wdata_q <= write_data;
            op_wr_q <= wr_en;
            cnt_q   <= 4'd0;
`ifdef SRAM_LINE_BUF_EN
            if (!wr_en && w_lb_hit) begin
              // Buffer hit: answer straight from the cached line, skip the SRAM.
              state_q     <= DONE;
              read_data_q <= w_req_word[0] ? lb_data_q[63:32] : lb_data_q[31:0];
            end else begin
              state_q <= ACCESS;
              we_n_q  <= ~wr_en;
            end
`else
            state_q <= ACCESS;
            we_n_q  <= ~wr_en;
`endif
          end
        end

        ACCESS: begin
          if (cnt_q == c_last_cnt) begin
            state_q <= DONE;
            we_n_q  <= 1'b1;
            if (!op_wr_q) begin
              read_data_q <= addr_q[0] ? SRAM_DQ[63:32] : SRAM_DQ[31:0];
`ifdef SRAM_LINE_BUF_EN
              lb_valid_q  <= 1'b1;
              lb_tag_q    <= addr_q[16:1];
              lb_data_q   <= SRAM_DQ;
`endif
            end
`ifdef SRAM_LINE_BUF_EN
            // Keep a cached line coherent with stores that land in it.
            else if (lb_valid_q && (lb_tag_q == addr_q[16:1])) begin
              if (addr_q[0]) begin
                lb_data_q[63:32] <= wdata_q;
              end else begin
                lb_data_q[31:0]  <= wdata_q;
              end
            end
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // In IDLE a fresh request must freeze the pipeline in the same cycle.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      IDLE:    ready = ~w_req;
      ACCESS:  ready = 1'b0;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign read_data = read_data_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_DQ   = we_n_q ? 64'bz : {32'b0, wdata_q};

endmodule

`default_nettype wire

// File: tb/tb_sram_controller.sv
// ============================================================================
// Module   : tb_sram_controller
// Purpose  : Directed scoreboard bench for sram_controller with an SRAM model.
// Options  : SRAM_LINE_BUF_EN selects buffered-read latency expectations.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_controller;

  localparam int          W    = 5;
  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        ready;
  logic        sram_we_n;
  logic [16:0] sram_addr;
  wire  [63:0] sram_dq;

  logic [31:0] mem [0:1023];

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] ref_mem [int];
  logic [31:0] sb [$];
  logic [31:0] last_rd = 32'd0;
  bit          bv = 1'b0;
  logic [15:0] btag = 16'd0;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_ADDR  (sram_addr),
    .SRAM_DQ    (sram_dq)
  );

  always #5 clk = ~clk;

  // SRAM model: returns the even/odd word pair, captures stores on WE_N low.
  assign sram_dq = sram_we_n ? {mem[{sram_addr[9:1], 1'b1}], mem[{sram_addr[9:1], 1'b0}]} : 64'bz;

  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[9:0]] <= sram_dq[31:0];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_rd = 32'd0;
    bv = 1'b0;
    #1;
    check("reset_ready", ready, 1);
    check("reset_we_n", sram_we_n, 1);
    check("reset_addr", sram_addr, 0);
    check("reset_rdata", read_data, 0);
  endtask

  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
    logic [31:0] off;
    logic [16:0] w;
    logic [31:0] exp_rd;
    bit          hit;
    int          exp_lat, lat, we_lo;
    bit          addr_ok, dq_ok;
    off = a - BASE;
    w   = off[18:2];
    hit = 1'b0;
`ifdef SRAM_LINE_BUF_EN
    if (!wr && bv && btag == w[16:1]) hit = 1'b1;
    if (!wr && !hit) begin bv = 1'b1; btag = w[16:1]; end
`endif
    exp_lat = hit ? 1 : W + 1;
    if (wr) begin
      exp_rd = last_rd;
      ref_mem[int'(a)] = d;
    end else begin
      exp_rd  = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'd0;
      last_rd = exp_rd;
    end
    sb.push_back(exp_rd);

    @(negedge clk);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    #1;
    check({tag, "_req_ready"}, ready, 0);

    lat = 0; we_lo = 0; addr_ok = 1'b1; dq_ok = 1'b1;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Scramble inputs: the latched request must be the only thing used.
        wr_en = 1'b0; rd_en = 1'b0; address = 32'hFFFF_FFFC; write_data = 32'hA5A5_A5A5;
      end
      #1;
      if (ready) begin
        lat = k;
      end else begin
        if (!sram_we_n) we_lo++;
        if (sram_addr !== w) addr_ok = 1'b0;
        if (wr && sram_dq !== {32'b0, d}) dq_ok = 1'b0;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_we_cycles"}, we_lo, wr ? W : 0);
    check({tag, "_addr"}, addr_ok, 1);
    if (wr) check({tag, "_dq"}, dq_ok, 1);
    check({tag, "_done_we_n"}, sram_we_n, 1);
    check({tag, "_rdata"}, read_data, sb.pop_front());
  endtask

  initial begin
    do_reset();

    access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, "wr1024");
    access(1'b0, 1'b1, 32'd1024, 32'h0,         "rd1024");
    access(1'b1, 1'b0, 32'd1028, 32'h1111_1111, "wr1028");
    access(1'b1, 1'b0, 32'd1024, 32'h2222_2222, "wr1024b");
    access(1'b0, 1'b1, 32'd1028, 32'h0,         "rd1028");
    access(1'b0, 1'b1, 32'd1024, 32'h0,         "rd1024b");
    access(1'b1, 1'b1, 32'd1032, 32'h5A5A_5A5A, "both1032");
    access(1'b0, 1'b1, 32'd1032, 32'h0,         "rd1032");

    // Reset in the third ACCESS cycle of a write aborts it.
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1040; write_data = 32'h7777_7777;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("abort_pre_we_n", sram_we_n, 0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("abort_we_n", sram_we_n, 1);
    check("abort_ready_req", ready, 0);
    check("abort_rdata", read_data, 0);
    check("abort_addr", sram_addr, 0);
    rst = 1'b0; wr_en = 1'b0;
    last_rd = 32'd0;
    bv = 1'b0;
    #1;
    check("abort_ready_idle", ready, 1);
    @(negedge clk);
    #1;
    check("abort_idle_we_n", sram_we_n, 1);
    check("abort_idle_ready", ready, 1);

    access(1'b0, 1'b1, 32'd1024, 32'h0,         "lb_rd1");
    access(1'b0, 1'b1, 32'd1024, 32'h0,         "lb_rd2");
    access(1'b0, 1'b1, 32'd1028, 32'h0,         "lb_rd3");
    access(1'b1, 1'b0, 32'd1028, 32'h3333_3333, "lb_wr");
    access(1'b0, 1'b1, 32'd1028, 32'h0,         "lb_rd4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
